// File: rtl/mimo_pkt_pkg.sv
// Shared sizing defaults and TX packet header field positions for the MIMO TX path.
package mimo_pkt_pkg;
  localparam int DEF_SLOT_AW     = 7;
  localparam int DEF_NSLOT_AW    = 2;
  localparam int HDR_PAYLOAD_MSB = 8;
  localparam int HDR_PAYLOAD_LSB = 2;
  localparam int HDR_RSSI_BIT    = 26;
  localparam int HDR_EOB_BIT     = 27;
  localparam int HDR_SOB_BIT     = 28;

  function automatic logic [HDR_PAYLOAD_MSB-HDR_PAYLOAD_LSB:0] hdr_payload(input logic [31:0] hdr);
    return hdr[HDR_PAYLOAD_MSB:HDR_PAYLOAD_LSB];
  endfunction
endpackage

// File: rtl/mimo_pkt_fifo_ram.sv
// Simple dual-port 32-bit RAM: synchronous write, asynchronous (same-cycle) read.
module mimo_pkt_fifo_ram
  import mimo_pkt_pkg::*;
#(
  parameter int AW = DEF_SLOT_AW + DEF_NSLOT_AW,
  parameter int DW = 32
) (
  input  logic          tx_clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge tx_clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/mimo_pkt_fifo.sv
// Slot-based TX packet buffer: packets commit on eop, reader sees show-ahead word, releases with skip.
// Optional counters behind PKT_FIFO_STATS_EN. Writes while full or after slot overflow are dropped (sticky overrun).
module mimo_pkt_fifo
  import mimo_pkt_pkg::*;
#(
  parameter int SLOT_AW  = DEF_SLOT_AW,
  parameter int NSLOT_AW = DEF_NSLOT_AW
) (
  input  logic                tx_clock,
  input  logic                reset,
  input  logic [31:0]         wr_data,
  input  logic                wr_en,
  input  logic                wr_eop,
  output logic                wr_full,
  output logic                overrun,
  output logic [31:0]         fifodata,
  output logic                pkt_waiting,
  input  logic                rdreq,
  input  logic                skip,
  output logic [NSLOT_AW:0]   used_slots
`ifdef PKT_FIFO_STATS_EN
  ,
  output logic [15:0]         stat_commit,
  output logic [15:0]         stat_drop,
  output logic [15:0]         stat_skip
`endif
);
  logic [NSLOT_AW-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [SLOT_AW-1:0]  wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [NSLOT_AW:0]   used_q, used_d;
  logic                overrun_q, overrun_d, drop_pkt_q, drop_pkt_d;
  logic                full, wr_accept, commit, drop_eop, do_skip;

  // used_q never exceeds NSLOTS, so its MSB alone marks full.
  assign full = used_q[NSLOT_AW];

  always_comb begin
    wr_slot_d  = wr_slot_q;
    wr_off_d   = wr_off_q;
    rd_slot_d  = rd_slot_q;
    rd_off_d   = rd_off_q;
    used_d     = used_q;
    overrun_d  = overrun_q;
    drop_pkt_d = drop_pkt_q;
    wr_accept  = wr_en && !full && !drop_pkt_q;
    commit     = wr_accept && wr_eop;
    drop_eop   = wr_en && wr_eop && !commit;
    do_skip    = skip && (used_q != '0);

    if (wr_accept) begin
      wr_off_d = wr_off_q + 1'b1;
      if (wr_eop) begin
        wr_off_d  = '0;
        wr_slot_d = wr_slot_q + 1'b1;
      end else if (wr_off_q == '1) begin
        drop_pkt_d = 1'b1;
        overrun_d  = 1'b1;
      end
    end else if (wr_en) begin
      // Once a packet loses a word, the rest of it is discarded up to its eop.
      overrun_d = 1'b1;
      if (wr_eop) begin
        wr_off_d   = '0;
        drop_pkt_d = 1'b0;
      end else begin
        drop_pkt_d = 1'b1;
      end
    end

    if (do_skip) begin
      rd_slot_d = rd_slot_q + 1'b1;
      rd_off_d  = '0;
    end else if (rdreq && (used_q != '0)) begin
      rd_off_d = rd_off_q + 1'b1;
    end

    if (commit && !do_skip)      used_d = used_q + 1'b1;
    else if (!commit && do_skip) used_d = used_q - 1'b1;
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      wr_slot_q  <= '0;
      wr_off_q   <= '0;
      rd_slot_q  <= '0;
      rd_off_q   <= '0;
      used_q     <= '0;
      overrun_q  <= 1'b0;
      drop_pkt_q <= 1'b0;
    end else begin
      wr_slot_q  <= wr_slot_d;
      wr_off_q   <= wr_off_d;
      rd_slot_q  <= rd_slot_d;
      rd_off_q   <= rd_off_d;
      used_q     <= used_d;
      overrun_q  <= overrun_d;
      drop_pkt_q <= drop_pkt_d;
    end
  end

  mimo_pkt_fifo_ram #(.AW(SLOT_AW + NSLOT_AW), .DW(32)) u_ram (
    .tx_clock (tx_clock),
    .we       (wr_accept),
    .waddr    ({wr_slot_q, wr_off_q}),
    .wdata    (wr_data),
    .raddr    ({rd_slot_q, rd_off_q}),
    .rdata    (fifodata)
  );

  assign wr_full     = full;
  assign overrun     = overrun_q;
  assign pkt_waiting = (used_q != '0);
  assign used_slots  = used_q;

`ifdef PKT_FIFO_STATS_EN
  logic [15:0] stat_commit_q, stat_commit_d, stat_drop_q, stat_drop_d, stat_skip_q, stat_skip_d;

  always_comb begin
    stat_commit_d = stat_commit_q;
    stat_drop_d   = stat_drop_q;
    stat_skip_d   = stat_skip_q;
    if (commit   && stat_commit_q != '1) stat_commit_d = stat_commit_q + 1'b1;
    if (drop_eop && stat_drop_q   != '1) stat_drop_d   = stat_drop_q + 1'b1;
    if (do_skip  && stat_skip_q   != '1) stat_skip_d   = stat_skip_q + 1'b1;
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      stat_commit_q <= '0;
      stat_drop_q   <= '0;
      stat_skip_q   <= '0;
    end else begin
      stat_commit_q <= stat_commit_d;
      stat_drop_q   <= stat_drop_d;
      stat_skip_q   <= stat_skip_d;
    end
  end

  assign stat_commit = stat_commit_q;
  assign stat_drop   = stat_drop_q;
  assign stat_skip   = stat_skip_q;
`endif
endmodule

// File: tb/tb_mimo_pkt_fifo.sv
// Bench for mimo_pkt_fifo: packet-queue reference model plus directed and random traffic.
module tb_mimo_pkt_fifo;
  localparam int NSLOTS     = 4;
  localparam int SLOT_WORDS = 128;

  logic        tx_clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0, wr_eop = 1'b0, rdreq = 1'b0, skip = 1'b0;
  logic        wr_full, overrun, pkt_waiting;
  logic [31:0] fifodata;
  logic [2:0]  used_slots;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Reference model: committed packets as a flat word queue plus per-packet lengths.
  logic [31:0] pdata[$];
  int          plen[$];
  logic [31:0] cur[$];
  bit          m_drop, m_ovr;
  int          m_rdoff;

  mimo_pkt_fifo dut (
    .tx_clock    (tx_clock),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_eop      (wr_eop),
    .wr_full     (wr_full),
    .overrun     (overrun),
    .fifodata    (fifodata),
    .pkt_waiting (pkt_waiting),
    .rdreq       (rdreq),
    .skip        (skip),
    .used_slots  (used_slots)
  );

  always #5 tx_clock = ~tx_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  pre;
    bit  skip_ok;
    if (reset) begin
      pdata.delete(); plen.delete(); cur.delete();
      m_drop = 0; m_ovr = 0; m_rdoff = 0;
      return;
    end
    pre     = plen.size();
    skip_ok = skip && (pre != 0);
    if (wr_en) begin
      if (pre < NSLOTS && !m_drop) begin
        cur.push_back(wr_data);
        if (wr_eop) begin
          plen.push_back(cur.size());
          foreach (cur[i]) pdata.push_back(cur[i]);
          cur.delete();
        end else if (cur.size() == SLOT_WORDS) begin
          m_drop = 1; m_ovr = 1;
        end
      end else begin
        m_ovr = 1;
        if (wr_eop) begin
          m_drop = 0; cur.delete();
        end else begin
          m_drop = 1;
        end
      end
    end
    if (skip_ok) begin
      for (int i = 0; i < plen[0]; i++) void'(pdata.pop_front());
      plen.delete(0);
      m_rdoff = 0;
    end else if (rdreq && pre != 0) begin
      m_rdoff = (m_rdoff + 1) % SLOT_WORDS;
    end
  endtask

  always @(negedge tx_clock) begin
    if (chk_en) begin
      check("used_slots", used_slots, plen.size());
      check("pkt_waiting", pkt_waiting, plen.size() != 0);
      check("wr_full", wr_full, plen.size() == NSLOTS);
      check("overrun", overrun, m_ovr);
      if (plen.size() != 0 && m_rdoff < plen[0])
        check("fifodata", fifodata, pdata[m_rdoff]);
    end
  end

  task automatic cycle(input bit we, input bit eop, input logic [31:0] d,
                       input bit rd, input bit sk, input bit rst = 0);
    wr_en = we; wr_eop = eop; wr_data = d; rdreq = rd; skip = sk; reset = rst;
    @(posedge tx_clock);
    model_step();
    #1;
  endtask

  task automatic write_pkt(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) cycle(1, i == n - 1, base + i, 0, 0);
  endtask

  initial begin
    int eop_div;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk_en = 1;
    check("rst_used", used_slots, 0);
    check("rst_waiting", pkt_waiting, 0);
    check("rst_full", wr_full, 0);
    check("rst_overrun", overrun, 0);

    // First packet: header visible right after the commit edge.
    cycle(1, 0, 32'h1000_0008, 0, 0);
    cycle(1, 0, 32'h0000_0100, 0, 0);
    cycle(1, 0, 32'h0011_0022, 0, 0);
    check("pre_commit_waiting", pkt_waiting, 0);
    cycle(1, 1, 32'h0033_0044, 0, 0);
    check("p1_waiting", pkt_waiting, 1);
    check("p1_hdr", fifodata, 32'h1000_0008);
    check("p1_used", used_slots, 1);
    cycle(0, 0, 0, 1, 0);
    check("p1_ts", fifodata, 32'h0000_0100);
    cycle(0, 0, 0, 1, 0);
    check("p1_s0", fifodata, 32'h0011_0022);
    cycle(0, 0, 0, 1, 0);
    check("p1_s1", fifodata, 32'h0033_0044);
    cycle(0, 0, 0, 1, 1);
    check("p1_skip_used", used_slots, 0);
    check("p1_skip_waiting", pkt_waiting, 0);
    cycle(0, 0, 0, 0, 1);
    check("skip_empty_used", used_slots, 0);

    // Fill all slots, then a write while full.
    for (int p = 0; p < NSLOTS; p++) write_pkt(3, 32'h2000_0000 + (p << 8));
    check("full_flag", wr_full, 1);
    check("full_used", used_slots, 4);
    check("full_ovr_before", overrun, 0);
    check("full_head", fifodata, 32'h2000_0000);
    cycle(1, 1, 32'hDEAD_BEEF, 0, 0);
    check("full_ovr", overrun, 1);
    check("full_used_after", used_slots, 4);
    cycle(0, 0, 0, 0, 1);
    check("full_clear", wr_full, 0);
    check("full_skip_used", used_slots, 3);
    check("full_next_head", fifodata, 32'h2000_0100);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

    // Slot overflow: 130 words then eop, nothing commits.
    cycle(0, 0, 0, 0, 0, 1);
    check("ovf_rst_ovr", overrun, 0);
    for (int i = 0; i < 130; i++) begin
      cycle(1, 0, 32'h3000_0000 + i, 0, 0);
      if (i == 126) check("ovf_127_ovr", overrun, 0);
      if (i == 127) check("ovf_128_ovr", overrun, 1);
    end
    cycle(1, 1, 32'h3000_FFFF, 0, 0);
    check("ovf_used", used_slots, 0);
    check("ovf_waiting", pkt_waiting, 0);
    write_pkt(4, 32'h4000_0000);
    check("ovf_reuse_used", used_slots, 1);
    check("ovf_reuse_hdr", fifodata, 32'h4000_0000);

    // Commit and skip together with two packets held, across slot wrap.
    write_pkt(2, 32'h5000_0000);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 32'h6000_0000 + (k << 8), 0, 0);
      cycle(1, 1, 32'h6000_0001 + (k << 8), 0, 1);
      check("cs_used", used_slots, 2);
    end
    check("cs_head", fifodata, 32'h6000_0300);

    // Reset while mid-packet with packets committed.
    cycle(1, 0, 32'h7000_0000, 0, 0);
    cycle(1, 0, 32'h7000_0001, 0, 0);
    cycle(1, 0, 32'h7000_0002, 0, 0, 1);
    check("mrst_used", used_slots, 0);
    check("mrst_waiting", pkt_waiting, 0);
    check("mrst_ovr", overrun, 0);
    write_pkt(3, 32'hABCD_0000);
    check("mrst_hdr", fifodata, 32'hABCD_0000);
    cycle(0, 0, 0, 0, 1);

    // Random traffic against the model.
    eop_div = 4;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: eop_div = 3;
          1: eop_div = 16;
          default: eop_div = 180;
        endcase
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, eop_div - 1) == 0, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
